// File: rtl/conv_read_sched.sv
// conv_read_sched: read-phase sequencer for the 1-D convolution engine.
// It takes over the X-memory address counter once both memories are loaded.
// For each output position it walks one M-tap window and drives the MAC strobes.
// Each finished accumulator value is offered on a valid/ready handshake.
module conv_read_sched #(
    parameter int N      = 20,
    parameter int M      = 13,
    parameter int AW     = 5,
    parameter int FW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_mem_full,
    input  logic          f_mem_full,
    output logic          en_ext_ctrl,
    output logic          ext_load_addr,
    output logic [AW-1:0] ext_load_addr_val,
    output logic          ext_incr_addr,
    output logic [FW-1:0] f_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          done
);

    // Number of output positions and the width of the window index.
    localparam int NW = N - M + 1;
    localparam int JW = (NW > 1) ? $clog2(NW) : 1;
    localparam int DW = 1;

    // Terminal counter values.
    // K_LAST is the tap index on the last RUN cycle; LAST then sees tap M-1.
    localparam logic [JW-1:0] J_LAST = JW'(N - M);
    localparam logic [FW-1:0] K_LAST = FW'((M >= 2) ? M - 2 : 0);
    localparam logic [DW-1:0] D_LAST = DW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_LAST,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [JW-1:0] j;          // window index
    logic [FW-1:0] k;          // tap index
    logic [DW-1:0] d;          // drain counter
    logic          tap_valid;  // a tap address is on the memories this cycle
    logic          tap_first;  // that tap is tap 0 of the window

    wire start = x_mem_full & f_mem_full;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one pass per window, then a handshake, then the next window or DONE.
    // NOTE: the default assignment at the top keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (M == 1) ? S_LAST : S_RUN;
            S_RUN:   if (k == K_LAST) state_nxt = S_LAST;
            S_LAST:  state_nxt = (RD_LAT == 0) ? S_OUT : S_DRAIN;
            S_DRAIN: if (d == D_LAST) state_nxt = S_OUT;
            S_OUT: begin
                if (m_ready) begin
                    state_nxt = (j == J_LAST) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Window index: cleared at frame start, advanced on each accepted output except the last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            j <= '0;
        end else if (state == S_IDLE && start) begin
            j <= '0;
        end else if (state == S_OUT && m_ready && j != J_LAST) begin
            j <= j + 1'b1;
        end
    end

    // Tap index: cleared in LOAD and stepped once per RUN cycle.
    // It therefore tracks the X address offset seen by the memories.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= '0;
        end else if (state == S_LOAD) begin
            k <= '0;
        end else if (state == S_RUN) begin
            k <= k + 1'b1;
        end
    end

    // Drain counter: waits out the memory read latency after the last tap address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d <= '0;
        end else if (state == S_LAST) begin
            d <= '0;
        end else if (state == S_DRAIN) begin
            d <= d + 1'b1;
        end
    end

    // Output decode from the current state.
    // The address counter is only touched in LOAD/RUN, so a stall in OUT issues nothing.
    always_comb begin
        en_ext_ctrl       = 1'b0;
        ext_load_addr     = 1'b0;
        ext_load_addr_val = '0;
        ext_incr_addr     = 1'b0;
        f_addr            = '0;
        m_valid           = 1'b0;
        done              = 1'b0;
        tap_valid         = 1'b0;
        unique case (state)
            S_IDLE: begin
            end
            S_LOAD: begin
                en_ext_ctrl       = 1'b1;
                ext_load_addr     = 1'b1;
                ext_load_addr_val = AW'(j);
            end
            S_RUN: begin
                en_ext_ctrl   = 1'b1;
                ext_incr_addr = 1'b1;
                f_addr        = k;
                tap_valid     = 1'b1;
            end
            S_LAST: begin
                en_ext_ctrl = 1'b1;
                f_addr      = k;
                tap_valid   = 1'b1;
            end
            S_DRAIN: begin
                en_ext_ctrl = 1'b1;
            end
            S_OUT: begin
                en_ext_ctrl = 1'b1;
                m_valid     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign tap_first = tap_valid && (k == '0);

    // MAC strobes line up with the read data.
    // They are the tap-valid/first-tap flags delayed by the memory read latency.
    generate
        if (RD_LAT == 0) begin : g_mac_comb
            assign mac_en  = tap_valid;
            assign mac_clr = tap_first;
        end else begin : g_mac_pipe
            logic mac_en_q;
            logic mac_clr_q;

            // Delay stage matching the one-cycle memory read.
            // NOTE: these flops are reset so that an abort drops the strobes immediately.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    mac_en_q  <= 1'b0;
                    mac_clr_q <= 1'b0;
                end else begin
                    mac_en_q  <= tap_valid;
                    mac_clr_q <= tap_first;
                end
            end

            assign mac_en  = mac_en_q;
            assign mac_clr = mac_clr_q;
        end
    endgenerate

endmodule

// File: tb/tb_conv_read_sched.sv
// Testbench for conv_read_sched: runs an RD_LAT=1 and an RD_LAT=0 instance side by side.
// Each instance is checked against a monitor that models the X address counter,
// the memories and the MAC, and compares finished sums with a direct convolution.
module tb_conv_read_sched;

    localparam int N  = 20;
    localparam int M  = 13;
    localparam int AW = 5;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x_mem_full = 1'b0;
    logic f_mem_full = 1'b0;
    int   rdy_mode = 0;  // 0: always ready, 1: random ready, 2: 5-cycle stall on output 3

    int xmem [32];
    int fmem [16];

    int n_checks = 0;
    int n_errors = 0;

    logic done_v    [2];
    logic any_out_v [2];
    logic load4_v   [2];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Direct convolution of window j.
    function automatic int ref_y(input int j);
        int s = 0;
        for (int i = 0; i < M; i++) s += xmem[j + i] * fmem[i];
        return s;
    endfunction

    task automatic load_mems();
        for (int i = 0; i < 32; i++) xmem[i] = (i < N) ? int'($urandom_range(0, 255)) : 0;
        for (int i = 0; i < 16; i++) fmem[i] = (i < M) ? int'($urandom_range(0, 255)) : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!(done_v[0] && done_v[1]) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_reached", {done_v[1], done_v[0]}, 3);
        tick();
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int RDL = g;

        logic          en_ext_ctrl;
        logic          ext_load_addr;
        logic [AW-1:0] ext_load_addr_val;
        logic          ext_incr_addr;
        logic [FW-1:0] f_addr;
        logic          mac_clr;
        logic          mac_en;
        logic          m_valid;
        logic          m_ready = 1'b0;
        logic          done;

        conv_read_sched #(
            .N(N), .M(M), .AW(AW), .FW(FW), .RD_LAT(RDL)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .x_mem_full       (x_mem_full),
            .f_mem_full       (f_mem_full),
            .en_ext_ctrl      (en_ext_ctrl),
            .ext_load_addr    (ext_load_addr),
            .ext_load_addr_val(ext_load_addr_val),
            .ext_incr_addr    (ext_incr_addr),
            .f_addr           (f_addr),
            .mac_clr          (mac_clr),
            .mac_en           (mac_en),
            .m_valid          (m_valid),
            .m_ready          (m_ready),
            .done             (done)
        );

        assign done_v[g]    = done;
        assign load4_v[g]   = ext_load_addr && (ext_load_addr_val == 5'd4);
        assign any_out_v[g] = |{en_ext_ctrl, ext_load_addr, ext_load_addr_val, ext_incr_addr,
                                f_addr, mac_clr, mac_en, m_valid, done};

        // Model state: environment address counter, MAC and frame progress.
        int addr_reg, addr_prev, faddr_prev;
        int mj, mac_cnt, incr_cnt, stall_cnt;
        int cyc, load_cyc, hs_cyc;
        int phase;  // 0 idle, 1 active, 2 done
        int acc;
        int stall_left;
        bit expect_load, prev_stall;

        // Downstream ready generator.
        always @(posedge clk) begin
            #2;
            if (!reset) stall_left = 5;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (m_valid && mj == 3 && stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
        end

        // Cycle monitor, sampled mid-cycle.
        always @(negedge clk) begin
            int xv, fv, a_next;
            cyc++;
            if (!reset) begin
                check($sformatf("u%0d.reset_outs", g),
                      {en_ext_ctrl, ext_load_addr, ext_load_addr_val, ext_incr_addr,
                       f_addr, mac_clr, mac_en, m_valid, done}, 0);
                phase = 0; expect_load = 0; prev_stall = 0;
                mj = 0; mac_cnt = 0; incr_cnt = 0; stall_cnt = 0; acc = 0;
                addr_reg = 0; addr_prev = 0; faddr_prev = 0;
            end else begin
                check($sformatf("u%0d.en_ext_ctrl", g), en_ext_ctrl, phase == 1);
                check($sformatf("u%0d.done", g), done, phase == 2);

                xv = (RDL == 1) ? xmem[addr_prev] : xmem[addr_reg];
                fv = (RDL == 1) ? fmem[faddr_prev] : fmem[int'(f_addr)];
                if (mac_clr) begin
                    check($sformatf("u%0d.clr_with_en", g), mac_en, 1);
                    check($sformatf("u%0d.clr_first_tap", g), mac_cnt, 0);
                end
                if (mac_en) begin
                    acc = mac_clr ? xv * fv : acc + xv * fv;
                    mac_cnt++;
                end

                if (ext_load_addr || ext_incr_addr)
                    check($sformatf("u%0d.strobe_excl", g), ext_load_addr && ext_incr_addr, 0);
                if (ext_load_addr || expect_load)
                    check($sformatf("u%0d.load_when", g), ext_load_addr, expect_load);

                a_next = addr_reg;
                if (ext_load_addr) begin
                    check($sformatf("u%0d.load_val", g), ext_load_addr_val, mj);
                    if (mj > 0) check($sformatf("u%0d.load_gap", g), cyc - hs_cyc, 1);
                    load_cyc = cyc; incr_cnt = 0; mac_cnt = 0; stall_cnt = 0;
                    a_next = int'(ext_load_addr_val);
                end else if (ext_incr_addr) begin
                    incr_cnt++;
                    a_next = addr_reg + 1;
                    check($sformatf("u%0d.addr_bound", g), a_next <= N - 1, 1);
                end
                expect_load = 0;

                if (prev_stall) check($sformatf("u%0d.valid_hold", g), m_valid, 1);
                if (m_valid) begin
                    check($sformatf("u%0d.stall_quiet", g), {ext_load_addr, ext_incr_addr, mac_en}, 0);
                    if (m_ready) begin
                        check($sformatf("u%0d.y%0d", g, mj), acc, ref_y(mj));
                        check($sformatf("u%0d.mac_count", g), mac_cnt, M);
                        check($sformatf("u%0d.incr_count", g), incr_cnt, M - 1);
                        check($sformatf("u%0d.latency", g), cyc - load_cyc, M + 1 + RDL + stall_cnt);
                        if (rdy_mode == 2 && mj == 3)
                            check($sformatf("u%0d.bp_stall", g), stall_cnt, 5);
                        hs_cyc = cyc;
                        if (mj == N - M) begin
                            phase = 2;
                        end else begin
                            mj++;
                            expect_load = 1;
                        end
                    end else begin
                        stall_cnt++;
                    end
                end
                prev_stall = m_valid && !m_ready;

                if (phase == 0 && x_mem_full && f_mem_full) begin
                    phase = 1; expect_load = 1; mj = 0;
                end

                addr_prev  = addr_reg;
                faddr_prev = int'(f_addr);
                addr_reg   = a_next % (1 << AW);
            end
        end
    end

    initial begin
        bit seen;

        // Held in reset with both flags high: outputs stay 0, then start on release.
        load_mems();
        rdy_mode   = 0;
        x_mem_full = 1'b1;
        f_mem_full = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        repeat (4) tick();
        x_mem_full = 1'b0;
        f_mem_full = 1'b0;
        wait_done(1000);
        repeat (5) tick();

        // Start gating with random downstream readiness.
        reset = 1'b0;
        load_mems();
        rdy_mode = 1;
        repeat (2) tick();
        reset      = 1'b1;
        x_mem_full = 1'b1;
        f_mem_full = 1'b0;
        repeat (10) tick();
        f_mem_full = 1'b1;
        tick();
        x_mem_full = 1'b0;
        f_mem_full = 1'b0;
        wait_done(2000);

        // Backpressure on output 3, then reset during window 4.
        reset = 1'b0;
        load_mems();
        rdy_mode = 2;
        repeat (2) tick();
        reset      = 1'b1;
        x_mem_full = 1'b1;
        f_mem_full = 1'b1;
        tick();
        x_mem_full = 1'b0;
        f_mem_full = 1'b0;
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (load4_v[1]) seen = 1;
        end
        check("window4_reached", seen, 1);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("async_reset_u0", any_out_v[0], 0);
        check("async_reset_u1", any_out_v[1], 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        check("idle_after_reset_u0", any_out_v[0], 0);
        check("idle_after_reset_u1", any_out_v[1], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
